// File: rtl/dmem_hs.sv
// Byte-addressed little-endian data memory with valid/ready request and response
// channels, a configurable number of wait states, and misalignment/range errors.
module dmem_hs #(
  parameter int WIDTH_ADDR_LENGTH = 32,
  parameter int WIDTH_DATA_LENGTH = 32,
  parameter int MEM_DEPTH         = 1024,
  parameter int WAIT_CYCLES       = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [WIDTH_ADDR_LENGTH-1:0] Addr,
  input  logic [WIDTH_DATA_LENGTH-1:0] DataW,
  input  logic                         MemRW,
  input  logic [1:0]                   LenSel,
  input  logic                         Unsigned,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [WIDTH_DATA_LENGTH-1:0] DataR,
  output logic                         resp_err
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e                         state_q, state_d;
  logic [3:0]                     cnt_q, cnt_d;
  logic                           req_ready_q, req_ready_d;
  logic                           resp_valid_q, resp_valid_d;
  logic [WIDTH_DATA_LENGTH-1:0]   data_r_q, data_r_d;
  logic                           resp_err_q, resp_err_d;
  logic [WIDTH_ADDR_LENGTH-1:0]   addr_q, addr_d;
  logic [WIDTH_DATA_LENGTH-1:0]   wdata_q, wdata_d;
  logic                           we_q, we_d;
  logic [1:0]                     len_q, len_d;
  logic                           uns_q, uns_d;

  logic [7:0]                     mem [MEM_DEPTH];

  logic [WIDTH_ADDR_LENGTH-1:0]   acc_addr;
  logic [WIDTH_DATA_LENGTH-1:0]   acc_wdata;
  logic                           acc_we;
  logic [1:0]                     acc_len;
  logic                           acc_uns;
  logic                           acc_err;
  logic [IDX_W-1:0]               idx;
  logic [7:0]                     rd_b [4];
  logic [WIDTH_DATA_LENGTH-1:0]   load_data;
  logic [3:0]                     be;
  logic                           do_access;
  logic                           mem_we;

  // In IDLE the access works on the live inputs (same-edge error/zero-wait
  // paths); in BUSY it works on the request captured at the accepting edge.
  always_comb begin
    if (state_q == IDLE) begin
      acc_addr  = Addr;
      acc_wdata = DataW;
      acc_we    = MemRW;
      acc_len   = LenSel;
      acc_uns   = Unsigned;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_we    = we_q;
      acc_len   = len_q;
      acc_uns   = uns_q;
    end
  end

  always_comb begin
    acc_err = ((acc_len == 2'b01) && acc_addr[0])
            || (acc_len[1] && (acc_addr[1:0] != 2'b00))
            || (acc_addr >= WIDTH_ADDR_LENGTH'(MEM_DEPTH));
    idx = acc_addr[IDX_W-1:0];
    for (int k = 0; k < 4; k++) rd_b[k] = mem[idx + IDX_W'(k)];
    case (acc_len)
      2'b00: begin
        load_data = {{24{~acc_uns & rd_b[0][7]}}, rd_b[0]};
        be        = 4'b0001;
      end
      2'b01: begin
        load_data = {{16{~acc_uns & rd_b[1][7]}}, rd_b[1], rd_b[0]};
        be        = 4'b0011;
      end
      default: begin
        load_data = {rd_b[3], rd_b[2], rd_b[1], rd_b[0]};
        be        = 4'b1111;
      end
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    data_r_d     = data_r_q;
    resp_err_d   = resp_err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    len_d        = len_q;
    uns_d        = uns_q;
    do_access    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d      = Addr;
          wdata_d     = DataW;
          we_d        = MemRW;
          len_d       = LenSel;
          uns_d       = Unsigned;
          req_ready_d = 1'b0;
          if (acc_err || (WAIT_CYCLES == 0)) begin
            do_access = 1'b1;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) do_access = 1'b1;
        else               cnt_d = cnt_q - 4'd1;
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          req_ready_d  = 1'b1;
          resp_valid_d = 1'b0;
          data_r_d     = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_access) begin
      state_d      = RESP;
      resp_valid_d = 1'b1;
      resp_err_d   = acc_err;
      data_r_d     = (acc_err || acc_we) ? '0 : load_data;
    end

    // An edge that lands while reset is held must never commit a store.
    mem_we = do_access & acc_we & ~acc_err & rst_n;
  end

  // NOTE: non-blocking assignments for all state so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      data_r_q     <= '0;
      resp_err_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      len_q        <= 2'b00;
      uns_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      data_r_q     <= data_r_d;
      resp_err_q   <= resp_err_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      len_q        <= len_d;
      uns_q        <= uns_d;
    end
  end

  // NOTE: the array has no reset so it maps onto plain RAM; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx + IDX_W'(k)] <= acc_wdata[8*k +: 8];
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign DataR      = data_r_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_hs.sv
// Directed bench for dmem_hs: one instance with two wait states and one with none.
module tb_dmem_hs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid2, req_valid0;
  logic [31:0] Addr, DataW;
  logic        MemRW, Unsigned, resp_ready;
  logic [1:0]  LenSel;

  logic        req_ready2, resp_valid2, resp_err2;
  logic        req_ready0, resp_valid0, resp_err0;
  logic [31:0] DataR2, DataR0;

  logic        use0;
  logic        req_ready_m, resp_valid_m, resp_err_m;
  logic [31:0] data_r_m;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_hs #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .Addr(Addr), .DataW(DataW), .MemRW(MemRW), .LenSel(LenSel), .Unsigned(Unsigned),
    .resp_valid(resp_valid2), .resp_ready(resp_ready), .DataR(DataR2), .resp_err(resp_err2)
  );

  dmem_hs #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
    .Addr(Addr), .DataW(DataW), .MemRW(MemRW), .LenSel(LenSel), .Unsigned(Unsigned),
    .resp_valid(resp_valid0), .resp_ready(resp_ready), .DataR(DataR0), .resp_err(resp_err0)
  );

  assign req_ready_m  = use0 ? req_ready0  : req_ready2;
  assign resp_valid_m = use0 ? resp_valid0 : resp_valid2;
  assign resp_err_m   = use0 ? resp_err0   : resp_err2;
  assign data_r_m     = use0 ? DataR0      : DataR2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    if (use0) req_valid0 = v;
    else      req_valid2 = v;
  endtask

  // Called just after a falling edge. Issues one request, measures the number of
  // edges (accepting edge = 1) until resp_valid, optionally stalls the response.
  task automatic xact(input string tag, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [1:0] len, input logic uns,
                      input int exp_edges, input logic [31:0] exp_data,
                      input logic exp_err, input int hold);
    int edges;
    logic [31:0] held;
    check({tag, ".req_ready"}, 32'(req_ready_m), 32'd1);
    Addr = a; DataW = d; MemRW = we; LenSel = len; Unsigned = uns;
    resp_ready = (hold == 0);
    set_valid(1'b1);
    @(posedge clk); #1;
    set_valid(1'b0);
    Addr = 32'hFFFF_FFFC; DataW = ~d; MemRW = ~we; LenSel = ~len; Unsigned = ~uns;
    edges = 1;
    while (!resp_valid_m && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, ".latency"}, 32'(edges), 32'(exp_edges));
    check({tag, ".data"}, data_r_m, exp_data);
    check({tag, ".err"}, 32'(resp_err_m), 32'(exp_err));
    if (hold > 0) begin
      held = data_r_m;
      Addr = 32'h0; MemRW = 1'b0; LenSel = 2'b10;
      set_valid(1'b1);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check({tag, ".hold_valid"}, 32'(resp_valid_m), 32'd1);
        check({tag, ".hold_data"}, data_r_m, held);
        check({tag, ".hold_ready"}, 32'(req_ready_m), 32'd0);
      end
      set_valid(1'b0);
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, ".resp_drop"}, 32'(resp_valid_m), 32'd0);
    check({tag, ".idle_ready"}, 32'(req_ready_m), 32'd1);
    if (hold > 0) begin
      @(posedge clk); #1;
      check({tag, ".no_stray"}, 32'(resp_valid_m), 32'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    use0 = 1'b0;
    rst_n = 1'b0; req_valid2 = 1'b0; req_valid0 = 1'b0;
    Addr = '0; DataW = '0; MemRW = 1'b0; LenSel = 2'b00; Unsigned = 1'b0;
    resp_ready = 1'b1;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    check("rst.req_ready", 32'(req_ready2), 32'd1);
    check("rst.resp_valid", 32'(resp_valid2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst.data", DataR2, 32'h0);
    check("rst.err", 32'(resp_err2), 32'd0);
    @(negedge clk);

    // Word store then load, two wait states.
    xact("st_w4", 1'b1, 32'h4, 32'h1234_5678, 2'b10, 1'b0, 3, 32'h0, 1'b0, 0);
    xact("ld_w4", 1'b0, 32'h4, 32'h0, 2'b10, 1'b0, 3, 32'h1234_5678, 1'b0, 0);

    // Asynchronous reset while a response is pending.
    Addr = 32'h4; MemRW = 1'b0; LenSel = 2'b10; resp_ready = 1'b0;
    req_valid2 = 1'b1;
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("arst.pre_valid", 32'(resp_valid2), 32'd1);
    check("arst.pre_data", DataR2, 32'h1234_5678);
    #2 rst_n = 1'b0;
    #1;
    check("arst.valid", 32'(resp_valid2), 32'd0);
    check("arst.ready", 32'(req_ready2), 32'd1);
    check("arst.data", DataR2, 32'h0);
    check("arst.err", 32'(resp_err2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; resp_ready = 1'b1;
    @(negedge clk);

    // Byte lanes and load extension.
    xact("st_w8",  1'b1, 32'h8, 32'h0,         2'b10, 1'b0, 3, 32'h0, 1'b0, 0);
    xact("st_b9",  1'b1, 32'h9, 32'hFFFF_FF80, 2'b00, 1'b0, 3, 32'h0, 1'b0, 0);
    xact("st_hA",  1'b1, 32'hA, 32'h1234_BEEF, 2'b01, 1'b0, 3, 32'h0, 1'b0, 0);
    xact("ld_w8",  1'b0, 32'h8, 32'h0, 2'b11, 1'b0, 3, 32'hBEEF_8000, 1'b0, 0);
    xact("ld_bs9", 1'b0, 32'h9, 32'h0, 2'b00, 1'b0, 3, 32'hFFFF_FF80, 1'b0, 0);
    xact("ld_bu9", 1'b0, 32'h9, 32'h0, 2'b00, 1'b1, 3, 32'h0000_0080, 1'b0, 0);
    xact("ld_hsA", 1'b0, 32'hA, 32'h0, 2'b01, 1'b0, 3, 32'hFFFF_BEEF, 1'b0, 0);
    xact("ld_huA", 1'b0, 32'hA, 32'h0, 2'b01, 1'b1, 3, 32'h0000_BEEF, 1'b0, 0);

    // Errors respond after one edge and leave the array untouched.
    xact("st_w0",    1'b1, 32'h0, 32'hA5A5_5A5A, 2'b10, 1'b0, 3, 32'h0, 1'b0, 0);
    xact("err_h1",   1'b1, 32'h1, 32'h0000_1111, 2'b01, 1'b0, 1, 32'h0, 1'b1, 0);
    xact("ld_w0",    1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 3, 32'hA5A5_5A5A, 1'b0, 0);
    xact("err_w2",   1'b0, 32'h2, 32'h0, 2'b10, 1'b0, 1, 32'h0, 1'b1, 0);
    xact("err_400",  1'b0, 32'h400, 32'h0, 2'b00, 1'b0, 1, 32'h0, 1'b1, 0);
    xact("err_alias", 1'b1, 32'h8000_0004, 32'h5555_5555, 2'b10, 1'b0, 1, 32'h0, 1'b1, 0);
    xact("ld_w4b",   1'b0, 32'h4, 32'h0, 2'b10, 1'b0, 3, 32'h1234_5678, 1'b0, 0);

    // Backpressure on the response channel.
    xact("bp_w4", 1'b0, 32'h4, 32'h0, 2'b10, 1'b0, 3, 32'h1234_5678, 1'b0, 3);

    // Reset while BUSY aborts a pending store.
    xact("st_wC0", 1'b1, 32'hC, 32'h0, 2'b10, 1'b0, 3, 32'h0, 1'b0, 0);
    Addr = 32'hC; DataW = 32'hDEAD_BEEF; MemRW = 1'b1; LenSel = 2'b10;
    req_valid2 = 1'b1;
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    @(posedge clk); #1;
    check("abort.busy_ready", 32'(req_ready2), 32'd0);
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xact("ld_wC", 1'b0, 32'hC, 32'h0, 2'b10, 1'b0, 3, 32'h0, 1'b0, 0);

    // Zero wait states: response one edge after accept.
    use0 = 1'b1;
    xact("z_st_wC", 1'b1, 32'hC, 32'hDEAD_BEEF, 2'b10, 1'b0, 1, 32'h0, 1'b0, 0);
    xact("z_ld_wC", 1'b0, 32'hC, 32'h0, 2'b10, 1'b0, 1, 32'hDEAD_BEEF, 1'b0, 0);
    xact("z_ld_bD", 1'b0, 32'hD, 32'h0, 2'b00, 1'b0, 1, 32'hFFFF_FFBE, 1'b0, 0);
    xact("z_err_3", 1'b0, 32'h3, 32'h0, 2'b01, 1'b0, 1, 32'h0, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_hs.md
Name: dmem_hs

Overview:
Byte-addressed, little-endian data memory for the RISC-V core with a valid/ready request channel and a valid/ready response channel. It has a configurable number of wait states. It supports byte, half and word access sizes, with signed or unsigned load extension. Misaligned and out-of-range accesses are reported through an error flag and never touch the array. It replaces the single-cycle data memory on the load/store path, allowing the pipeline to stall on slow memory.

Parameters:
WIDTH_ADDR_LENGTH, 32, address width in bits.
WIDTH_DATA_LENGTH, 32, data width in bits; fixed at 32 in this revision.
MEM_DEPTH, 1024, array size in bytes; must be a power of two.
WAIT_CYCLES, 2, extra cycles between request accept and response; range 0..15.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request.
Addr  in  WIDTH_ADDR_LENGTH  byte address.
DataW  in  32  store data; low bytes are used for byte and half stores.
MemRW  in  1  1 = store, 0 = load.
LenSel  in  2  00 = byte, 01 = half, 10 or 11 = word.
Unsigned  in  1  1 = zero-extend loads, 0 = sign-extend loads; ignored for stores.
resp_valid  out  1  response present.
resp_ready  in  1  consumer accepts the response.
DataR  out  32  extended load data; 0 for stores and errors.
resp_err  out  1  the request was misaligned or out of range.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - req_ready=1, resp_valid=0, DataR=0, resp_err=0, wait counter=0.
  - Array contents are not reset.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: req_ready=1.
    - On req_valid=1, the request is accepted at this edge. Addr, DataW, MemRW, LenSel and Unsigned are latched.
    - If the request is in error, or WAIT_CYCLES=0: the access or error evaluation is performed at this edge and the state goes to RESP.
    - Otherwise: the counter is loaded with WAIT_CYCLES-1 and the state goes to BUSY.
  - BUSY: req_ready=0.
    - The counter decrements each cycle.
    - When the counter is 0, the access is performed at that edge and the state goes to RESP.
  - RESP: req_ready=0, resp_valid=1.
    - DataR and resp_err are held stable until resp_ready=1.
    - On resp_ready=1, the state goes to IDLE and resp_valid falls at that edge.
    - The next request is accepted no earlier than the following edge; there is no same-cycle turnaround.
- Latency:
  - resp_valid rises WAIT_CYCLES+1 edges after the accepting edge.
  - Error responses rise 1 edge after the accepting edge, regardless of WAIT_CYCLES.
  - Throughput is one request per WAIT_CYCLES+2 cycles when resp_ready is held at 1.
- Error conditions (resp_err=1, DataR=0, array untouched):
  - Half access with Addr[0]=1.
  - Word access with Addr[1:0]≠0.
  - Any access with Addr ≥ MEM_DEPTH, compared over the full address width with no aliasing.
- Stores:
  - Byte store writes DataW[7:0] to mem[Addr].
  - Half store writes DataW[15:0] to bytes Addr..Addr+1, little-endian.
  - Word store writes all 4 bytes.
  - Store response: DataR=0, resp_err=0.
- Loads:
  - Byte load returns mem[Addr], extended per Unsigned.
  - Half load returns {mem[A+1],mem[A]}, extended per Unsigned.
  - Word load returns the 4 bytes unmodified.
- Ordering: a load accepted after a store's response observes the stored data. Only one request is outstanding at a time.
- Input handling: inputs are ignored outside the accepting edge. Changes to request signals while in BUSY or RESP have no effect.
- Reset mid-operation:
  - Reset asserted in BUSY aborts the request; a pending store is not written.
  - Reset asserted in RESP drops the response.
  - A store already committed on entry to RESP remains in the array.
- resp_ready=1 outside RESP is ignored.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles, then release -> req_ready=1, resp_valid=0, DataR=0, resp_err=0. Also assert rst_n mid-cycle -> outputs clear immediately, without waiting for a clock edge.
2. Word store then word load, WAIT_CYCLES=2: store 0x1234_5678 to Addr 0x4, then load Addr 0x4 -> each resp_valid rises exactly 3 edges after its accept; the load returns DataR=0x1234_5678, resp_err=0.
3. Byte lanes and extension:
   - Store word 0 to Addr 0x8, store byte 0x80 to Addr 0x9, store half 0xBEEF to Addr 0xA.
   - Load word at 0x8 -> 0xBEEF_8000.
   - Load byte signed at 0x9 -> 0xFFFF_FF80; load byte unsigned at 0x9 -> 0x0000_0080.
   - Load half signed at 0xA -> 0xFFFF_BEEF.
4. Errors:
   - Half store to Addr 0x1 -> resp_err=1 after 1 edge; a subsequent word load at 0x0 is unchanged.
   - Word load at Addr 0x2 -> resp_err=1, DataR=0.
   - Load at Addr 0x400 -> resp_err=1.
5. Backpressure: hold resp_ready=0 for 3 cycles during a load of 0x1234_5678 -> resp_valid stays 1, DataR stays stable, req_ready stays 0, and a new req_valid is not accepted; raising resp_ready -> back to IDLE on the next edge.
6. Reset mid-BUSY: accept a word store of 0xDEAD_BEEF to Addr 0xC (old value 0), then assert rst_n=0 one cycle later; reload -> DataR=0x0000_0000. Repeat with WAIT_CYCLES=0 -> the response arrives 1 edge after accept.
